lag_periodic_traffic_source: RTL

- Deterministic traffic generator at one mesh tile; drives the tile's network entry port, directly upstream of the router's TILE input.
- Creates fixed-length packets to one predefined destination at a fixed injection period.
- Queues packet requests with their creation timestamps, so measured latency includes source queueing.
- Serialises each packet onto one entry PL, honouring per-PL backpressure.

---
 rtl/lag_periodic_traffic_source.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/lag_periodic_traffic_source.sv
// Periodic traffic source for one mesh tile: creates fixed-length packets to a
// single destination at a fixed period, queues the requests with their
// creation time, and serialises each packet onto one entry PL under
// per-PL backpressure.
module lag_periodic_traffic_source #(
  parameter int XDIM          = 4,
  parameter int YDIM          = 4,
  parameter int XPOS          = 0,
  parameter int YPOS          = 0,
  parameter int NP            = 2,
  parameter int PACKET_LENGTH = 4,
  parameter int INJ_PERIOD    = 16,
  parameter int DEST_X        = 1,
  parameter int DEST_Y        = 0,
  parameter int NUM_PACKETS   = 0,
  parameter int QUEUE_DEPTH   = 8,
  localparam int PLW = (NP > 1) ? $clog2(NP) : 1,
  localparam int XW  = $clog2(XDIM),
  localparam int YW  = $clog2(YDIM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [NP-1:0]  network_ready,
  output logic           flit_valid,
  output logic [PLW-1:0] flit_pl,
  output logic           flit_head,
  output logic           flit_tail,
  output logic [XW-1:0]  flit_dx,
  output logic [YW-1:0]  flit_dy,
  output logic [15:0]    flit_seq,
  output logic [31:0]    flit_ts,
  output logic [31:0]    flits_sent_o,
  output logic [31:0]    drops_o,
  output logic           done
);

  localparam int AW  = $clog2(QUEUE_DEPTH);
  localparam int PCW = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
  localparam int FCW = (PACKET_LENGTH > 1) ? $clog2(PACKET_LENGTH) : 1;
  localparam logic [FCW-1:0] LAST_FLIT = FCW'(PACKET_LENGTH - 1);
  localparam logic [PCW-1:0] LAST_TICK = PCW'(INJ_PERIOD - 1);

  // Reject configurations the datapath cannot represent.
  if (PACKET_LENGTH < 1 || INJ_PERIOD < 1 || QUEUE_DEPTH < 2 ||
      (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || NP < 1 ||
      XDIM < 2 || YDIM < 2 || XPOS >= XDIM || YPOS >= YDIM ||
      DEST_X >= XDIM || DEST_Y >= YDIM || NUM_PACKETS < 0) begin : g_param_check
    $error("lag_periodic_traffic_source: illegal parameter set");
  end

  typedef enum logic [0:0] {S_IDLE, S_BODY} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t         state;
  logic [31:0]    time_cnt;
  logic [PCW-1:0] per_cnt;
  logic [31:0]    attempts;
  logic [31:0]    flits_sent;
  logic [31:0]    drops;
  logic [15:0]    seq;
  logic           done_q;

  logic [31:0]    ts_mem  [QUEUE_DEPTH];
  logic [15:0]    seq_mem [QUEUE_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    q_count;

  logic [PLW-1:0] pl_q;
  logic [FCW-1:0] fcnt;
  logic [15:0]    seq_q;
  logic [31:0]    ts_q;

  logic           creation_over;
  logic           create;
  logic           q_empty;
  logic           q_full;
  logic           pop;
  logic           push;
  logic           drop;
  logic           done_now;
  logic [PLW-1:0] low_pl;

  assign creation_over = (NUM_PACKETS != 0) && (attempts >= 32'(NUM_PACKETS));
  assign create        = enable && (per_cnt == '0) && !creation_over;
  assign q_empty       = (q_count == '0);
  assign q_full        = (q_count == (AW+1)'(QUEUE_DEPTH));
  assign pop           = (state == S_IDLE) && !q_empty && (|network_ready);
  assign push          = create && (!q_full || pop);
  assign drop          = create && q_full && !pop;
  assign done_now      = creation_over && q_empty && (state == S_IDLE);

  // Lowest-index ready PL, used only when a new packet starts.
  always_comb begin
    low_pl = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (network_ready[i]) low_pl = PLW'(i);
    end
  end

  // Flit outputs follow the FSM and the ready inputs in the transfer cycle;
  // payload fields read zero whenever no flit is presented.
  always_comb begin
    flit_valid = 1'b0;
    flit_pl    = '0;
    flit_head  = 1'b0;
    flit_tail  = 1'b0;
    flit_seq   = '0;
    flit_ts    = '0;
    case (state)
      S_IDLE: begin
        if (pop) begin
          flit_valid = 1'b1;
          flit_pl    = low_pl;
          flit_head  = 1'b1;
          flit_tail  = (PACKET_LENGTH == 1);
          flit_seq   = seq_mem[rd_ptr];
          flit_ts    = ts_mem[rd_ptr];
        end
      end
      S_BODY: begin
        if (network_ready[pl_q]) begin
          flit_valid = 1'b1;
          flit_pl    = pl_q;
          flit_tail  = (fcnt == LAST_FLIT);
          flit_seq   = seq_q;
          flit_ts    = ts_q;
        end
      end
      default: ;
    endcase
  end

  assign flit_dx      = flit_valid ? XW'(DEST_X) : '0;
  assign flit_dy      = flit_valid ? YW'(DEST_Y) : '0;
  assign flits_sent_o = flits_sent;
  assign drops_o      = drops;
  assign done         = done_q | done_now;

  // Free-running time base and the enable-gated injection period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_cnt <= '0;
      per_cnt  <= '0;
    end else begin
      time_cnt <= time_cnt + 32'd1;
      if (enable) per_cnt <= (per_cnt == LAST_TICK) ? '0 : per_cnt + PCW'(1);
    end
  end

  // Creation bookkeeping: attempts, sequence numbers, drops, sticky done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attempts   <= '0;
      seq        <= '0;
      drops      <= '0;
      flits_sent <= '0;
      done_q     <= 1'b0;
    end else begin
      if (create)     attempts   <= sat_inc(attempts);
      if (push)       seq        <= seq + 16'd1;
      if (drop)       drops      <= sat_inc(drops);
      if (flit_valid) flits_sent <= sat_inc(flits_sent);
      if (done_now)   done_q     <= 1'b1;
    end
  end

  // Request queue pointers and occupancy; a pop frees its slot for a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + (AW+1)'(1);
        2'b01:   q_count <= q_count - (AW+1)'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Request queue storage: creation timestamp and sequence number.
  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_ptr]  <= time_cnt;
      seq_mem[wr_ptr] <= seq;
    end
  end

  // Serialiser FSM: head in IDLE on pop, remaining flits in BODY on the latched PL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      fcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            fcnt <= FCW'(1);
            if (PACKET_LENGTH > 1) state <= S_BODY;
          end
        end
        S_BODY: begin
          if (network_ready[pl_q]) begin
            if (fcnt == LAST_FLIT) state <= S_IDLE;
            else                   fcnt  <= fcnt + FCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-packet fields latched at the head so every flit carries the same values.
  always_ff @(posedge clk) begin
    if (pop) begin
      pl_q  <= low_pl;
      seq_q <= seq_mem[rd_ptr];
      ts_q  <= ts_mem[rd_ptr];
    end
  end

endmodule
